// File: rtl/fmap_window_tx.sv
// Requantised feature-map store streaming K x K x CHANNELS conv windows.
// Option FMAP_TX_SKIP_PAD_EN: drop out-of-range taps instead of sending zeros.
module fmap_window_tx #(
  parameter int WIDTH    = 32,
  parameter int HEIGHT   = 32,
  parameter int CHANNELS = 16,
  parameter int K        = 3,
  parameter int PAD      = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            wr_en,
  input  logic [$clog2(CHANNELS)-1:0]     wr_ch,
  input  logic [$clog2(WIDTH*HEIGHT)-1:0] wr_addr,
  input  logic signed [20:0]              wr_data,
  output logic                            wr_drop,
  input  logic                            start,
  output logic                            busy,
  output logic                            done,
  output logic                            m_valid,
  input  logic                            m_ready,
  output logic signed [7:0]               m_data,
  output logic                            m_pad,
  output logic                            m_last
);

  localparam int DEPTH = CHANNELS * WIDTH * HEIGHT;
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = $clog2(CHANNELS);
  localparam int YW    = $clog2(HEIGHT);
  localparam int XW    = $clog2(WIDTH);
  localparam int KW    = $clog2(K + 1);

`ifdef FMAP_TX_SKIP_PAD_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    SEND,
    FIN
  } state_t;

  // First/last in-range window offset for an output coordinate
  function automatic int lo_f(input int p);
    return (SKIP && p < PAD) ? PAD - p : 0;
  endfunction

  function automatic int hi_f(input int p, input int size);
    return (SKIP && p + K - 1 - PAD > size - 1) ?
      size - 1 + PAD - p : K - 1;
  endfunction

  state_t r_state, w_state_n;

  logic [7:0]        r_mem [DEPTH];
  logic signed [7:0] r_data;
  logic              r_valid, r_pad, r_last, r_final, r_drop;
  logic [YW-1:0]     r_i, w_ni;
  logic [XW-1:0]     r_j, w_nj;
  logic [KW-1:0]     r_m, r_n, w_nm, w_nn;
  logic [CW-1:0]     r_c, w_nc;

  logic          w_busy, w_load, w_init, w_valid_n;
  logic          w_pad, w_last, w_final;
  logic          w_c_end, w_n_end, w_m_end, w_j_end, w_i_end;
  logic [AW-1:0] w_rd_addr, w_wr_addr;
  logic [7:0]    w_wq;
  int            w_iy, w_ix;

  assign w_busy  = (r_state != IDLE);
  assign busy    = w_busy;
  assign done    = (r_state == FIN);
  assign m_valid = r_valid;
  assign m_data  = r_data;
  assign m_pad   = SKIP ? 1'b0 : r_pad;
  assign m_last  = r_last;
  assign wr_drop = r_drop;

  assign w_wq = wr_data[20] ? 8'd0 :
                (wr_data > 21'sd127) ? 8'd127 : wr_data[7:0];
  assign w_wr_addr = AW'(int'(wr_ch) * (WIDTH * HEIGHT)
                         + int'(wr_addr));

  always_ff @(posedge clk) begin
    if (wr_en && !w_busy)
      r_mem[w_wr_addr] <= w_wq;
  end

  // Counters hold the tap to issue next; this decodes it and its successor
  always_comb begin
    w_iy    = int'(r_i) + int'(r_m) - PAD;
    w_ix    = int'(r_j) + int'(r_n) - PAD;
    w_pad   = (w_iy < 0) || (w_iy >= HEIGHT) ||
              (w_ix < 0) || (w_ix >= WIDTH);
    w_rd_addr = AW'((int'(r_c) * HEIGHT + w_iy) * WIDTH + w_ix);
    w_c_end = (int'(r_c) == CHANNELS - 1);
    w_n_end = (int'(r_n) == hi_f(int'(r_j), WIDTH));
    w_m_end = (int'(r_m) == hi_f(int'(r_i), HEIGHT));
    w_j_end = (int'(r_j) == WIDTH - 1);
    w_i_end = (int'(r_i) == HEIGHT - 1);
    w_last  = w_c_end && w_n_end && w_m_end;
    w_final = w_last && w_j_end && w_i_end;
    w_ni = r_i;
    w_nj = r_j;
    w_nm = r_m;
    w_nn = r_n;
    w_nc = r_c + 1'b1;
    if (w_c_end) begin
      w_nc = '0;
      w_nn = r_n + 1'b1;
      if (w_n_end) begin
        w_nn = KW'(lo_f(int'(r_j)));
        w_nm = r_m + 1'b1;
        if (w_m_end) begin
          w_nj = r_j + 1'b1;
          if (w_j_end) begin
            w_nj = '0;
            w_ni = r_i + 1'b1;
          end
          w_nm = KW'(lo_f(int'(w_ni)));
          w_nn = KW'(lo_f(int'(w_nj)));
        end
      end
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_valid_n = r_valid;
    w_load    = 1'b0;
    w_init    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_state_n = FETCH;
          w_init    = 1'b1;
        end
      end
      FETCH: begin
        w_load    = 1'b1;
        w_valid_n = 1'b1;
        w_state_n = SEND;
      end
      SEND: begin
        if (r_valid && m_ready) begin
          if (r_final) begin
            w_state_n = FIN;
            w_valid_n = 1'b0;
          end else begin
            w_load = 1'b1;
          end
        end
      end
      FIN: w_state_n = IDLE;
      default: w_state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_n;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_pad   <= 1'b0;
      r_last  <= 1'b0;
      r_final <= 1'b0;
      r_drop  <= 1'b0;
      r_i     <= '0;
      r_j     <= '0;
      r_m     <= '0;
      r_n     <= '0;
      r_c     <= '0;
    end else begin
      r_valid <= w_valid_n;
      r_drop  <= wr_en && w_busy;
      if (w_init) begin
        r_i <= '0;
        r_j <= '0;
        r_c <= '0;
        r_m <= KW'(lo_f(0));
        r_n <= KW'(lo_f(0));
      end else if (w_load) begin
        r_pad   <= w_pad;
        r_last  <= w_last;
        r_final <= w_final;
        if (w_pad) r_data <= '0;
        else       r_data <= r_mem[w_rd_addr];
        r_i <= w_ni;
        r_j <= w_nj;
        r_m <= w_nm;
        r_n <= w_nn;
        r_c <= w_nc;
      end
    end
  end

endmodule

// File: tb/tb_fmap_window_tx.sv
// Bench for fmap_window_tx: requant table, random map, stall/abort frames.
// Reference stream is rebuilt from window rules over a shadow map.
module tb_fmap_window_tx;

  localparam int W   = 5;
  localparam int H   = 4;
  localparam int C   = 4;
  localparam int K   = 3;
  localparam int PAD = 1;
  localparam int NP  = W * H;
  localparam int CHW = $clog2(C);
  localparam int PW  = $clog2(NP);

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic wr_en = 1'b0;
  logic start = 1'b0;
  logic m_ready = 1'b0;
  logic [CHW-1:0] wr_ch = '0;
  logic [PW-1:0] wr_addr = '0;
  logic signed [20:0] wr_data = '0;
  logic wr_drop, busy, done, m_valid, m_pad, m_last;
  logic signed [7:0] m_data;

  always #5 clk = ~clk;

  fmap_window_tx #(
    .WIDTH(W), .HEIGHT(H), .CHANNELS(C), .K(K), .PAD(PAD)
  ) dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_ch(wr_ch), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_drop(wr_drop),
    .start(start), .busy(busy), .done(done),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_pad(m_pad), .m_last(m_last)
  );

  typedef struct {
    logic [7:0] d;
    logic p;
    logic l;
    int src;
  } beat_t;

  typedef struct {
    logic signed [20:0] din;
    logic [7:0] q;
  } vec_t;

  beat_t exq[$];
  logic [7:0] capd[$];
  logic [7:0] gm [C][NP];
  vec_t tbl [9];
  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] rq(input logic signed [20:0] d);
    if (d < 0) return 8'd0;
    if (d > 127) return 8'd127;
    return d[7:0];
  endfunction

  task automatic wr(input int ch, input int pix,
                    input logic signed [20:0] d);
    wr_en = 1'b1;
    wr_ch = CHW'(ch);
    wr_addr = PW'(pix);
    wr_data = d;
    gm[ch][pix] = rq(d);
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic gen_expected();
    exq.delete();
    for (int i = 0; i < H; i++)
      for (int j = 0; j < W; j++) begin
        beat_t t;
        for (int m = 0; m < K; m++)
          for (int n = 0; n < K; n++)
            for (int c = 0; c < C; c++) begin
              int y, x;
              bit p;
              beat_t b;
              y = i + m - PAD;
              x = j + n - PAD;
              p = (y < 0 || y >= H || x < 0 || x >= W);
`ifdef FMAP_TX_SKIP_PAD_EN
              if (p) continue;
`endif
              b.d = p ? 8'd0 : gm[c][y * W + x];
              b.p = p;
              b.l = 1'b0;
              b.src = p ? -1 : c * NP + y * W + x;
              exq.push_back(b);
            end
        t = exq[exq.size() - 1];
        t.l = 1'b1;
        exq[exq.size() - 1] = t;
      end
  endtask

  task automatic run_frame(input int pct, input bit hold,
                           input bit poke, input int abort_at);
    int n, cyc, ph;
    bit fin, stl, rdy, seen;
    logic [7:0] hd;
    logic hp, hl;
    n = 0; cyc = 0; ph = 0;
    fin = 0; stl = 0; seen = 0;
    hd = '0; hp = 0; hl = 0;
    capd.delete();
    start = 1'b1;
    @(negedge clk);
    start = hold;
    chk("busy_after_start", 32'(busy), 1);
    chk("valid_in_fetch", 32'(m_valid), 0);
    @(negedge clk);
    chk("first_beat_latency", 32'(m_valid), 1);
    while (!fin && cyc < 20000) begin
      if (stl)
        chk("stall_hold", {m_valid, m_pad, m_last, m_data},
            {1'b1, hp, hl, hd});
      if (pct == 100 && seen && n < exq.size())
        chk("no_bubble", 32'(m_valid), 1);
      if (abort_at > 0 && n == abort_at) begin
        rst = 1'b0;
        #1;
        chk("abort_outputs",
            {busy, done, m_valid, m_pad, m_last, wr_drop, m_data}, 0);
        m_ready = 1'b0;
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (20) begin
          @(negedge clk);
          chk("abort_no_done", {done, busy}, 0);
        end
        return;
      end
      if (done) begin
        fin = 1;
        start = 1'b0;
        chk("beat_count", n, exq.size());
      end else begin
        rdy = ($urandom_range(99) < pct);
        m_ready = rdy;
        if (m_valid) seen = 1;
        if (m_valid && rdy) begin
          if (n < exq.size())
            chk($sformatf("beat%0d", n), {m_pad, m_last, m_data},
                {exq[n].p, exq[n].l, exq[n].d});
          else
            chk("extra_beat", n, exq.size());
          capd.push_back(m_data);
          n++;
        end
        stl = m_valid && !rdy;
        hd = m_data;
        hp = m_pad;
        hl = m_last;
        if (poke) begin
          if (ph == 0 && n >= 40) begin
            wr_en = 1'b1;
            wr_ch = '0;
            wr_addr = '0;
            wr_data = 21'sd99;
            start = 1'b1;
            ph = 1;
          end else if (ph == 1) begin
            chk("wr_drop_pulse", 32'(wr_drop), 1);
            wr_en = 1'b0;
            start = hold;
            ph = 2;
          end else if (ph == 2) begin
            chk("wr_drop_clear", 32'(wr_drop), 0);
            ph = 3;
          end
        end
      end
      @(negedge clk);
      cyc++;
    end
    chk("frame_done", 32'(fin), 1);
    chk("idle_after_done", {busy, m_valid, done}, 0);
    @(negedge clk);
    chk("stays_idle", {busy, m_valid, done}, 0);
  endtask

  initial begin
    tbl[0] = '{-21'sd5, 8'd0};
    tbl[1] = '{21'sd300, 8'd127};
    tbl[2] = '{21'sd64, 8'd64};
    tbl[3] = '{21'sd0, 8'd0};
    tbl[4] = '{21'sd127, 8'd127};
    tbl[5] = '{21'sd128, 8'd127};
    tbl[6] = '{-21'sd1048576, 8'd0};
    tbl[7] = '{21'sd1048575, 8'd127};
    tbl[8] = '{21'sd1, 8'd1};

    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_done", 32'(done), 0);
    chk("reset_valid", 32'(m_valid), 0);
    chk("reset_outs", {m_pad, m_last, wr_drop, m_data}, 0);
    rst = 1'b1;
    @(negedge clk);

    for (int k = 0; k < 9; k++) wr(0, k, tbl[k].din);
    for (int c = 0; c < C; c++)
      for (int p = 0; p < NP; p++)
        if (!(c == 0 && p < 9)) begin
          int v;
          v = int'($urandom_range(600)) - 200;
          wr(c, p, 21'(v));
        end
    @(negedge clk);
    chk("no_drop_idle", 32'(wr_drop), 0);
    gen_expected();

    // full rate, start held high through the final handshake
    run_frame(100, 1'b1, 1'b0, 0);
    for (int k = 0; k < 9; k++) begin
      int idx;
      idx = -1;
      for (int b = 0; b < exq.size(); b++)
        if (idx < 0 && exq[b].src == k) idx = b;
      if (idx >= 0 && idx < capd.size())
        chk($sformatf("requant%0d", k), capd[idx], tbl[k].q);
      else
        chk("requant_missing", capd.size(), exq.size());
    end

    run_frame(50, 1'b0, 1'b1, 0);
    run_frame(70, 1'b0, 1'b0, 100);
    run_frame(50, 1'b0, 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
